// File: rtl/hash_bus_tx_pkg.sv
// Shared types for the PMOD D hash bus output stage: FSM states and FIFO entry layout.
package blake2_bus_pkg;

  localparam int BUS_W   = 8;
  localparam int ENTRY_W = BUS_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    WAIT_LOW
  } bus_state_t;

  typedef struct packed {
    logic             last;
    logic [BUS_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/hash_bus_tx_if.sv
// Core-side byte stream plus PMOD D host pins; master is the transmitter, slave the core/host side.
interface hash_bus_tx_if
  import blake2_bus_pkg::*;
#(
  parameter int DEPTH = 32
) ();

  logic                   in_valid_i;
  logic [BUS_W-1:0]       in_data_i;
  logic                   in_last_i;
  logic                   in_ready_o;
  logic                   host_ack_i;
  logic [BUS_W-1:0]       hash_o;
  logic                   hash_valid_o;
  logic                   hash_last_o;
  logic [$clog2(DEPTH):0] level_o;
  logic                   proto_err_o;
  logic                   timeout_o;

  modport master (
    input  in_valid_i, in_data_i, in_last_i, host_ack_i,
    output in_ready_o, hash_o, hash_valid_o, hash_last_o, level_o, proto_err_o, timeout_o
  );

  modport slave (
    output in_valid_i, in_data_i, in_last_i, host_ack_i,
    input  in_ready_o, hash_o, hash_valid_o, hash_last_o, level_o, proto_err_o, timeout_o
  );

endinterface

// File: rtl/hash_bus_tx_fifo.sv
// Synchronous DEPTH x W FIFO with show-ahead head; push ignored when full, pop ignored when empty.
module bus_fifo
  import blake2_bus_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int W     = ENTRY_W
) (
  input  logic                   clk_io_bus,
  input  logic                   rst_async,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk_io_bus) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_io_bus or posedge rst_async) begin
    if (rst_async) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hash_bus_tx.sv
// Buffers digest bytes and hands them to the host over a four-phase valid/ack handshake.
// Empty-FIFO write to valid: 2 cycles; ack pin to valid low: 3 cycles; in_ready_o drops only when the FIFO is full.
module hash_bus_tx
  import blake2_bus_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic           clk_io_bus,
  input logic           rst_async,
  hash_bus_tx_if.master bus
);

  localparam int TC_W = $clog2(TIMEOUT_CYC);
  localparam logic [TC_W-1:0] TC_MAX = TC_W'(TIMEOUT_CYC - 1);

  bus_state_t             state;
  entry_t                 head;
  entry_t                 wr_entry;
  entry_t                 out_q;
  logic                   valid_q;
  logic                   proto_q;
  logic                   timeout_q;
  logic [TC_W-1:0]        tcnt;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   ready;
  logic                   push;
  logic                   pop;
  logic                   ack_s1;
  logic                   ack_s2;
  logic                   ack_d;
  logic                   ack_rise;

  assign ready    = ~fifo_full;
  assign push     = bus.in_valid_i & ready;
  assign pop      = (state == IDLE) & ~fifo_empty;
  assign wr_entry = '{last: bus.in_last_i, data: bus.in_data_i};

  bus_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk_io_bus (clk_io_bus),
    .rst_async  (rst_async),
    .push       (push),
    .din        (wr_entry),
    .pop        (pop),
    .dout       (head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // host_ack_i is asynchronous: two flops to resolve metastability, a third for edge detection.
  always_ff @(posedge clk_io_bus or posedge rst_async) begin
    if (rst_async) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
      ack_d  <= 1'b0;
    end else begin
      ack_s1 <= bus.host_ack_i;
      ack_s2 <= ack_s1;
      ack_d  <= ack_s2;
    end
  end

  assign ack_rise = ack_s2 & ~ack_d;

  always_ff @(posedge clk_io_bus or posedge rst_async) begin
    if (rst_async) begin
      state     <= IDLE;
      out_q     <= '0;
      valid_q   <= 1'b0;
      tcnt      <= '0;
      proto_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (ack_rise && state == IDLE) proto_q <= 1'b1;
      if (state != IDLE && tcnt == TC_MAX) timeout_q <= 1'b1;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            out_q   <= head;
            valid_q <= 1'b1;
            tcnt    <= '0;
            state   <= PRESENT;
          end
        end
        PRESENT: begin
          if (ack_s2) begin
            valid_q <= 1'b0;
            tcnt    <= '0;
            state   <= WAIT_LOW;
          end else if (tcnt != TC_MAX) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WAIT_LOW: begin
          if (!ack_s2) begin
            tcnt  <= '0;
            state <= IDLE;
          end else if (tcnt != TC_MAX) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready_o   = ready;
  assign bus.hash_o       = out_q.data;
  assign bus.hash_last_o  = out_q.last;
  assign bus.hash_valid_o = valid_q;
  assign bus.level_o      = fifo_count;
  assign bus.proto_err_o  = proto_q;
  assign bus.timeout_o    = timeout_q;

endmodule

// File: tb/tb_hash_bus_tx.sv
// Directed bench for hash_bus_tx: inputs driven and outputs sampled 1 ns after each rising edge.
module tb_hash_bus_tx;

  localparam int DEPTH = 32;
  localparam int TOUT  = 1024;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  hash_bus_tx_if #(.DEPTH(DEPTH)) bus ();

  hash_bus_tx #(
    .DEPTH       (DEPTH),
    .TIMEOUT_CYC (TOUT)
  ) dut (
    .clk_io_bus (clk),
    .rst_async  (rst),
    .bus        (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host side of one handshake; returns the byte seen and ok=0 if valid never rose or fell.
  task automatic host_recv(output logic [7:0] d, output logic l, output bit ok);
    int n;
    ok = 1'b0;
    d  = 8'h00;
    l  = 1'b0;
    n  = 0;
    while (bus.hash_valid_o !== 1'b1 && n < 200) begin tick(); n++; end
    if (bus.hash_valid_o !== 1'b1) return;
    d = bus.hash_o;
    l = bus.hash_last_o;
    bus.host_ack_i = 1'b1;
    n = 0;
    while (bus.hash_valid_o !== 1'b0 && n < 20) begin tick(); n++; end
    bus.host_ack_i = 1'b0;
    if (bus.hash_valid_o !== 1'b0) return;
    repeat (3) tick();
    ok = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid_i = 1'b0; bus.in_data_i = 8'h00; bus.in_last_i = 1'b0; bus.host_ack_i = 1'b0;
    repeat (3) tick();
    total++; if (bus.hash_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.hash_valid_o); end
    rst = 1'b0;
    tick();
    total++; if (bus.hash_o !== 8'h00) begin bad++; $display("FAIL rst_hash got=%h want=00", bus.hash_o); end
    total++; if (bus.hash_last_o !== 1'b0) begin bad++; $display("FAIL rst_last got=%b want=0", bus.hash_last_o); end
    total++; if (bus.level_o !== 6'd0) begin bad++; $display("FAIL rst_level got=%0d want=0", bus.level_o); end
    total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", bus.in_ready_o); end
    total++; if ({bus.proto_err_o, bus.timeout_o} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b want=00", {bus.proto_err_o, bus.timeout_o}); end
  endtask

  task automatic test_single();
    bus.in_valid_i = 1'b1; bus.in_data_i = 8'hA5; bus.in_last_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    total++; if (bus.level_o !== 6'd1) begin bad++; $display("FAIL single_level1 got=%0d want=1", bus.level_o); end
    total++; if (bus.hash_valid_o !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b want=0", bus.hash_valid_o); end
    tick();
    total++; if ({bus.hash_valid_o, bus.hash_last_o, bus.hash_o} !== {2'b11, 8'hA5}) begin bad++; $display("FAIL single_present got=%b%b_%h want=11_a5", bus.hash_valid_o, bus.hash_last_o, bus.hash_o); end
    total++; if (bus.level_o !== 6'd0) begin bad++; $display("FAIL single_level0 got=%0d want=0", bus.level_o); end
    repeat (4) tick();
    bus.host_ack_i = 1'b1;
    repeat (2) tick();
    total++; if (bus.hash_valid_o !== 1'b1) begin bad++; $display("FAIL ack_lat2 got=%b want=1", bus.hash_valid_o); end
    tick();
    total++; if (bus.hash_valid_o !== 1'b0) begin bad++; $display("FAIL ack_lat3 got=%b want=0", bus.hash_valid_o); end
    total++; if (bus.hash_o !== 8'hA5) begin bad++; $display("FAIL wait_low_hold got=%h want=a5", bus.hash_o); end
    bus.host_ack_i = 1'b0;
    repeat (4) tick();
    total++; if ({bus.hash_valid_o, bus.proto_err_o, bus.level_o} !== 8'd0) begin bad++; $display("FAIL single_done got=%b_%b_%0d want=0_0_0", bus.hash_valid_o, bus.proto_err_o, bus.level_o); end
  endtask

  task automatic test_full();
    logic [7:0] d;
    logic       l;
    bit         ok;
    for (int i = 0; i < 32; i++) begin
      bus.in_valid_i = 1'b1; bus.in_data_i = 8'(i); bus.in_last_i = (i == 31);
      tick();
    end
    total++; if (bus.level_o !== 6'd31) begin bad++; $display("FAIL full_level31 got=%0d want=31", bus.level_o); end
    total++; if ({bus.hash_valid_o, bus.hash_o} !== {1'b1, 8'h00}) begin bad++; $display("FAIL full_first got=%b_%h want=1_00", bus.hash_valid_o, bus.hash_o); end
    bus.in_data_i = 8'h20; bus.in_last_i = 1'b1;
    tick();
    total++; if ({bus.level_o, bus.in_ready_o} !== {6'd32, 1'b0}) begin bad++; $display("FAIL full_ready got=%0d_%b want=32_0", bus.level_o, bus.in_ready_o); end
    bus.in_data_i = 8'h21;
    tick();
    bus.in_valid_i = 1'b0;
    total++; if (bus.level_o !== 6'd32) begin bad++; $display("FAIL full_reject got=%0d want=32", bus.level_o); end
    host_recv(d, l, ok);
    total++; if ({ok, d, l} !== {1'b1, 8'h00, 1'b0}) begin bad++; $display("FAIL full_rx0 got=%b_%h_%b want=1_00_0", ok, d, l); end
    total++; if ({bus.level_o, bus.in_ready_o} !== {6'd32, 1'b0}) begin bad++; $display("FAIL full_prepop got=%0d_%b want=32_0", bus.level_o, bus.in_ready_o); end
    tick();
    total++; if ({bus.level_o, bus.in_ready_o, bus.hash_o} !== {6'd31, 1'b1, 8'h01}) begin bad++; $display("FAIL full_postpop got=%0d_%b_%h want=31_1_01", bus.level_o, bus.in_ready_o, bus.hash_o); end
    for (int i = 1; i < 33; i++) begin
      host_recv(d, l, ok);
      total++; if ({ok, d, l} !== {1'b1, 8'(i), (i >= 31)}) begin bad++; $display("FAIL full_rx%0d got=%b_%h_%b want=1_%h_%b", i, ok, d, l, 8'(i), (i >= 31)); end
    end
    total++; if (bus.level_o !== 6'd0) begin bad++; $display("FAIL full_drained got=%0d want=0", bus.level_o); end
  endtask

  task automatic test_push_pop();
    logic [7:0] d;
    logic       l;
    bit         ok;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid_i = 1'b1; bus.in_data_i = 8'(8'h40 + i); bus.in_last_i = 1'b0;
      tick();
    end
    bus.in_valid_i = 1'b0;
    total++; if (bus.level_o !== 6'd5) begin bad++; $display("FAIL pp_level_pre got=%0d want=5", bus.level_o); end
    host_recv(d, l, ok);
    total++; if ({ok, d} !== {1'b1, 8'h40}) begin bad++; $display("FAIL pp_rx40 got=%b_%h want=1_40", ok, d); end
    bus.in_valid_i = 1'b1; bus.in_data_i = 8'h46; bus.in_last_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    total++; if ({bus.level_o, bus.hash_o} !== {6'd5, 8'h41}) begin bad++; $display("FAIL pp_same_cycle got=%0d_%h want=5_41", bus.level_o, bus.hash_o); end
    for (int i = 1; i < 7; i++) begin
      host_recv(d, l, ok);
      total++; if ({ok, d, l} !== {1'b1, 8'(8'h40 + i), (i == 6)}) begin bad++; $display("FAIL pp_rx%0d got=%b_%h_%b want=1_%h_%b", i, ok, d, l, 8'(8'h40 + i), (i == 6)); end
    end
    total++; if (bus.level_o !== 6'd0) begin bad++; $display("FAIL pp_drained got=%0d want=0", bus.level_o); end
  endtask

  task automatic test_proto();
    logic [7:0] d;
    logic       l;
    bit         ok;
    total++; if (bus.proto_err_o !== 1'b0) begin bad++; $display("FAIL proto_pre got=%b want=0", bus.proto_err_o); end
    bus.host_ack_i = 1'b1;
    repeat (4) tick();
    bus.host_ack_i = 1'b0;
    repeat (4) tick();
    total++; if ({bus.proto_err_o, bus.hash_valid_o} !== 2'b10) begin bad++; $display("FAIL proto_set got=%b%b want=10", bus.proto_err_o, bus.hash_valid_o); end
    bus.in_valid_i = 1'b1; bus.in_data_i = 8'h3C; bus.in_last_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    repeat (11) tick();
    total++; if ({bus.hash_valid_o, bus.hash_o} !== {1'b1, 8'h3C}) begin bad++; $display("FAIL proto_waits got=%b_%h want=1_3c", bus.hash_valid_o, bus.hash_o); end
    host_recv(d, l, ok);
    total++; if ({ok, d, l} !== {1'b1, 8'h3C, 1'b1}) begin bad++; $display("FAIL proto_rx got=%b_%h_%b want=1_3c_1", ok, d, l); end
    total++; if (bus.proto_err_o !== 1'b1) begin bad++; $display("FAIL proto_sticky got=%b want=1", bus.proto_err_o); end
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    logic       l;
    bit         ok;
    bus.in_valid_i = 1'b1; bus.in_data_i = 8'h77; bus.in_last_i = 1'b0;
    tick();
    bus.in_valid_i = 1'b0;
    tick();
    total++; if (bus.hash_valid_o !== 1'b1) begin bad++; $display("FAIL to_present got=%b want=1", bus.hash_valid_o); end
    repeat (TOUT - 1) tick();
    total++; if (bus.timeout_o !== 1'b0) begin bad++; $display("FAIL to_early got=%b want=0", bus.timeout_o); end
    tick();
    total++; if ({bus.timeout_o, bus.hash_valid_o} !== 2'b11) begin bad++; $display("FAIL to_set got=%b%b want=11", bus.timeout_o, bus.hash_valid_o); end
    host_recv(d, l, ok);
    total++; if ({ok, d, bus.timeout_o} !== {1'b1, 8'h77, 1'b1}) begin bad++; $display("FAIL to_late_ack got=%b_%h_%b want=1_77_1", ok, d, bus.timeout_o); end
  endtask

  task automatic test_reset_mid();
    int n;
    int stale;
    for (int i = 0; i < 11; i++) begin
      bus.in_valid_i = 1'b1; bus.in_data_i = 8'(8'h50 + i); bus.in_last_i = 1'b0;
      tick();
    end
    bus.in_valid_i = 1'b0;
    bus.host_ack_i = 1'b1;
    n = 0;
    while (bus.hash_valid_o !== 1'b0 && n < 20) begin tick(); n++; end
    total++; if ({bus.hash_valid_o, bus.level_o} !== {1'b0, 6'd10}) begin bad++; $display("FAIL rm_wait_low got=%b_%0d want=0_10", bus.hash_valid_o, bus.level_o); end
    tick();
    rst = 1'b1;
    #1;
    total++; if ({bus.hash_valid_o, bus.hash_last_o, bus.hash_o} !== 10'd0) begin bad++; $display("FAIL rm_out got=%b%b_%h want=00_00", bus.hash_valid_o, bus.hash_last_o, bus.hash_o); end
    total++; if ({bus.level_o, bus.proto_err_o, bus.timeout_o} !== 8'd0) begin bad++; $display("FAIL rm_state got=%0d_%b%b want=0_00", bus.level_o, bus.proto_err_o, bus.timeout_o); end
    bus.host_ack_i = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.hash_valid_o !== 1'b0 || bus.level_o !== 6'd0) stale++;
    end
    total++; if (stale !== 0) begin bad++; $display("FAIL rm_stale got=%0d want=0", stale); end
    total++; if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b want=1", bus.in_ready_o); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_full();
    test_push_pop();
    test_proto();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
